linear_inverse_tonemap: RTL and testbench

- Streaming linear inverse-tonemapping pixel unit.
- Expands one low-dynamic-range code word per clock into a wider high-dynamic-range code word.
- Uses a fixed linear full-scale mapping, so 0 maps to 0 and input full-scale maps to output full-scale.
- Sits in the pixel datapath with no handshake: one sample in and one result out every cycle, timing closed at a 15 ns clock.

---
 rtl/linear_inverse_tonemap_if.sv | 12 +
 rtl/linear_inverse_tonemap.sv | 63 ++++++
 tb/tb_linear_inverse_tonemap.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/linear_inverse_tonemap_if.sv
// Pixel stream bundle for the linear inverse-tonemap unit: one LDR code in and
// one HDR code out per clock, with no handshake.
interface linear_inverse_tonemap_if #(
  parameter int unsigned LIT_IN  = 8,
  parameter int unsigned LIT_OUT = 16
);
  logic [LIT_IN-1:0]  LIT_in;
  logic [LIT_OUT-1:0] LIT_out;

  modport master (output LIT_in, input LIT_out);
  modport slave  (input LIT_in, output LIT_out);
endinterface

// File: rtl/linear_inverse_tonemap.sv
// Streaming linear inverse tonemap: LIT_out = round-half-up(LIT_in * MAXO / MAXI),
// with a single registered stage so the latency is exactly one clock.
module linear_inverse_tonemap #(
  parameter int unsigned LIT_IN  = 8,
  parameter int unsigned LIT_OUT = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  linear_inverse_tonemap_if.slave px
);

  if (LIT_IN < 2 || LIT_IN > 16) begin : gen_bad_in
    $error("linear_inverse_tonemap: LIT_IN must be in 2..16");
  end
  if (LIT_OUT < LIT_IN || LIT_OUT > 24) begin : gen_bad_out
    $error("linear_inverse_tonemap: LIT_OUT must be in LIT_IN..24");
  end

  logic [LIT_OUT-1:0] lit_d;
  logic [LIT_OUT-1:0] lit_q;

  if (LIT_OUT == LIT_IN) begin : gen_identity
    // Equal widths make the rescale an exact identity.
    always_comb begin
      lit_d = LIT_OUT'(px.LIT_in);
    end
  end else begin : gen_scale
    // floor(n / MAXI) is computed as (n * RECIP) >> SH_W with RECIP = ceil(2^SH_W / MAXI).
    // The reciprocal error is below MAXI and n stays below 2^(LIT_IN+LIT_OUT), so
    // SH_W = 2*LIT_IN + LIT_OUT keeps the quotient exact for every input code.
    localparam int unsigned SH_W   = 2 * LIT_IN + LIT_OUT;
    localparam int unsigned NUM_W  = LIT_IN + LIT_OUT;
    localparam int unsigned PROD_W = NUM_W + SH_W + 1;

    localparam logic [127:0] MAXI_W = (128'd1 << LIT_IN) - 128'd1;
    localparam logic [127:0] MAXO_W = (128'd1 << LIT_OUT) - 128'd1;
    localparam logic [127:0] RECIP  = ((128'd1 << SH_W) + MAXI_W - 128'd1) / MAXI_W;

    // MAXO and the rounding bias are folded into the reciprocal ahead of time, so the
    // per-pixel work is one narrow-by-constant multiply plus a constant add.
    localparam logic [PROD_W-1:0] COEF = PROD_W'(MAXO_W * RECIP);
    localparam logic [PROD_W-1:0] BIAS = PROD_W'((MAXI_W >> 1) * RECIP);

    logic [PROD_W-1:0] prod_c;

    always_comb begin
      prod_c = PROD_W'(px.LIT_in) * COEF + BIAS;
      lit_d  = LIT_OUT'(prod_c >> SH_W);
    end
  end

  // Single output register; reset clears it asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lit_q <= '0;
    end else begin
      lit_q <= lit_d;
    end
  end

  assign px.LIT_out = lit_q;

endmodule

// File: tb/tb_linear_inverse_tonemap.sv
// Directed and streaming checks of linear_inverse_tonemap in 8->16, 8->12 and
// 10->10 configurations driven in lockstep.
module tb_linear_inverse_tonemap;

  logic clk;
  logic rst;

  int unsigned n_total;
  int unsigned n_bad;

  linear_inverse_tonemap_if #(.LIT_IN(8),  .LIT_OUT(16)) if16 ();
  linear_inverse_tonemap_if #(.LIT_IN(8),  .LIT_OUT(12)) if12 ();
  linear_inverse_tonemap_if #(.LIT_IN(10), .LIT_OUT(10)) if10 ();

  linear_inverse_tonemap #(.LIT_IN(8), .LIT_OUT(16)) u_dut16 (
    .clk (clk),
    .rst (rst),
    .px  (if16)
  );

  linear_inverse_tonemap #(.LIT_IN(8), .LIT_OUT(12)) u_dut12 (
    .clk (clk),
    .rst (rst),
    .px  (if12)
  );

  linear_inverse_tonemap #(.LIT_IN(10), .LIT_OUT(10)) u_dut10 (
    .clk (clk),
    .rst (rst),
    .px  (if10)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic longint unsigned ref_map(input longint unsigned x,
                                              input int unsigned wi,
                                              input int unsigned wo);
    longint unsigned maxi;
    longint unsigned maxo;
    maxi = (64'd1 << wi) - 64'd1;
    maxo = (64'd1 << wo) - 64'd1;
    return (x * maxo + maxi / 64'd2) / maxi;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic drive(input int unsigned a, input int unsigned b);
    if16.LIT_in = 8'(a);
    if12.LIT_in = 8'(a);
    if10.LIT_in = 10'(b);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input int unsigned a, input int unsigned b);
    check_eq({tag, "/16"}, 32'(if16.LIT_out), 32'(ref_map(64'(a), 8, 16)));
    check_eq({tag, "/12"}, 32'(if12.LIT_out), 32'(ref_map(64'(a), 8, 12)));
    check_eq({tag, "/id"}, 32'(if10.LIT_out), 32'(b));
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "/16"}, 32'(if16.LIT_out), 32'd0);
    check_eq({tag, "/12"}, 32'(if12.LIT_out), 32'd0);
    check_eq({tag, "/id"}, 32'(if10.LIT_out), 32'd0);
  endtask

  initial begin
    int unsigned ep_in  [4];
    int unsigned ep_exp [4];
    int unsigned rd_in  [4];
    int unsigned rd_exp [4];
    int unsigned a;
    int unsigned b;

    ep_in  = '{0, 255, 1, 128};
    ep_exp = '{0, 65535, 257, 32896};
    rd_in  = '{1, 128, 254, 255};
    rd_exp = '{16, 2056, 4079, 4095};

    n_total = 0;
    n_bad   = 0;
    rst     = 1'b0;
    drive(200, 200);

    // Reset held for three edges with a live input.
    for (int i = 0; i < 3; i++) begin
      tick();
      check_zero($sformatf("rst_hold%0d", i));
    end
    rst = 1'b1;
    tick();
    check_eq("rst_rel/16", 32'(if16.LIT_out), 32'd51400);
    check_eq("rst_rel/12", 32'(if12.LIT_out), 32'd3212);
    check_eq("rst_rel/id", 32'(if10.LIT_out), 32'd200);

    // Endpoints 8->16, back to back.
    for (int i = 0; i < 4; i++) begin
      drive(ep_in[i], ep_in[i]);
      tick();
      check_eq($sformatf("endpt%0d/16", i), 32'(if16.LIT_out), 32'(ep_exp[i]));
    end

    // Rounding 8->12.
    for (int i = 0; i < 4; i++) begin
      drive(rd_in[i], rd_in[i] + 700);
      tick();
      check_eq($sformatf("round%0d/12", i), 32'(if12.LIT_out), 32'(rd_exp[i]));
      check_eq($sformatf("round%0d/id", i), 32'(if10.LIT_out), 32'(rd_in[i] + 700));
    end

    // Every code of every configuration, one per clock.
    for (int i = 0; i < 1024; i++) begin
      a = 32'(i) % 256;
      b = 32'(i);
      drive(a, b);
      tick();
      check_all($sformatf("exh%0d", i), a, b);
    end

    // Random stream.
    for (int i = 0; i < 10000; i++) begin
      a = $urandom_range(0, 255);
      b = $urandom_range(0, 1023);
      drive(a, b);
      tick();
      check_all($sformatf("rnd%0d", i), a, b);
    end

    // Reset asserted between edges mid-stream, then released.
    drive(77, 500);
    tick();
    check_all("pre_mid", 77, 500);
    #3 rst = 1'b0;
    #1 check_zero("mid_async");
    drive(99, 321);
    tick();
    check_zero("mid_hold");
    rst = 1'b1;
    tick();
    check_all("mid_resume", 99, 321);
    for (int i = 0; i < 20; i++) begin
      a = $urandom_range(0, 255);
      b = $urandom_range(0, 1023);
      drive(a, b);
      tick();
      check_all($sformatf("post%0d", i), a, b);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
